screen_console_ctrl: RTL and testbench

- Text-console write controller for the VGA character screen RAM: 80 rows x 128 columns, one byte per cell, 10240 cells, 15-bit linear address.
- Accepts a character stream from the processor I/O path over a valid/ready handshake and maintains a cursor.
- Interprets control codes, then drives the RAM write port and a dedicated scroll read port.
- Handles clear-screen and hardware scroll autonomously, so the CPU never touches RAM addresses.

---
 rtl/screen_console_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_screen_console_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_console_ctrl.sv
// screen_console_ctrl
// Text-console write controller for the character screen RAM (COLS x ROWS
// cells, one byte each, linear address row*COLS + col). Accepts characters
// over a valid/ready handshake, keeps the cursor, interprets control codes,
// and runs clear-screen and hardware scroll without CPU involvement.
//
// Build option: define CONSOLE_SCROLL_EN to build the SCROLL/FILL engine.
// Without it, advancing past the last row wraps the cursor to row 0 with no
// RAM traffic, and the scroll read port is tied off.
module screen_console_ctrl #(
  parameter int COLS   = 128,
  parameter int ROWS   = 80,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              ram_rsel,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [7:0]        ram_rdata,
  output logic [6:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              busy
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_ROW  = 7'(ROWS - 1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);

`ifdef CONSOLE_SCROLL_EN
  // Last source cell index of the copy phase: every cell except the top row
  // moves up by one row.
  localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'((ROWS - 1) * COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCROLL,
    S_FILL
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR
  } state_t;
`endif

  // Control state
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_k, w_k_nxt;
  logic [6:0]        r_row, w_row_nxt;
  logic [6:0]        r_col, w_col_nxt;

  // Registered RAM write port
  logic              r_we, w_we_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;

  // Decode helpers
  logic              w_accept;
  logic              w_printable;
  logic              w_adv;
  logic [ADDR_W-1:0] w_cur_addr;

`ifdef CONSOLE_SCROLL_EN
  // Registered scroll read port; r_copy marks a write whose data is the
  // RAM read result returned this cycle.
  logic              r_rsel, w_rsel_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic              r_copy, w_copy_nxt;
`endif

  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign w_cur_addr  = ADDR_W'(r_row) * ROW_STEP + ADDR_W'(r_col);

  // Next-state, cursor and RAM-port decode for the console FSM
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_adv       = 1'b0;
`ifdef CONSOLE_SCROLL_EN
    w_rsel_nxt  = 1'b0;
    w_raddr_nxt = '0;
    w_copy_nxt  = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_cur_addr;
            w_wdata_nxt = in_char;
            if (r_col == LAST_COL) begin
              w_col_nxt = '0;
              w_adv     = 1'b1;
            end else begin
              w_col_nxt = r_col + 7'd1;
            end
          end else begin
            case (in_char)
              8'h0A: begin
                w_col_nxt = '0;
                w_adv     = 1'b1;
              end
              8'h0D: w_col_nxt = '0;
              8'h08: begin
                // Backspace never retreats to the previous row.
                if (r_col != '0) begin
                  w_col_nxt   = r_col - 7'd1;
                  w_we_nxt    = 1'b1;
                  w_waddr_nxt = w_cur_addr - ONE;
                  w_wdata_nxt = 8'h00;
                end
              end
              8'h0C: begin
                // First clear write goes out together with the accept.
                w_state_nxt = S_CLEAR;
                w_k_nxt     = '0;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
                w_we_nxt    = 1'b1;
                w_waddr_nxt = '0;
                w_wdata_nxt = 8'h00;
              end
              default: ;
            endcase
          end
        end
      end

      S_CLEAR: begin
        // r_k is the address being written this cycle.
        if (r_k != LAST_CELL) begin
          w_k_nxt     = r_k + ONE;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_k + ONE;
          w_wdata_nxt = 8'h00;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

`ifdef CONSOLE_SCROLL_EN
      S_SCROLL: begin
        // r_k is the destination of the read issued this cycle; its data
        // lands next cycle and is written straight back one row higher.
        w_we_nxt    = 1'b1;
        w_waddr_nxt = r_k;
        w_copy_nxt  = 1'b1;
        if (r_k != SCR_LAST) begin
          w_k_nxt     = r_k + ONE;
          w_rsel_nxt  = 1'b1;
          w_raddr_nxt = r_k + ROW_STEP + ONE;
        end else begin
          // r_k already equals the address of the final copy write, which
          // is what FILL expects to find on entry.
          w_state_nxt = S_FILL;
        end
      end

      S_FILL: begin
        if (r_k != LAST_CELL) begin
          w_k_nxt     = r_k + ONE;
          w_we_nxt    = 1'b1;
          w_waddr_nxt = r_k + ONE;
          w_wdata_nxt = 8'h00;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`endif

      default: w_state_nxt = S_IDLE;
    endcase

    // Row advance shared by newline and end-of-line wrap.
    if (w_adv) begin
      if (r_row == LAST_ROW) begin
`ifdef CONSOLE_SCROLL_EN
        w_state_nxt = S_SCROLL;
        w_k_nxt     = '0;
        w_rsel_nxt  = 1'b1;
        w_raddr_nxt = ROW_STEP;
`else
        w_row_nxt   = '0;
`endif
      end else begin
        w_row_nxt = r_row + 7'd1;
      end
    end
  end

  // State, cursor and RAM-port registers; reset aborts any clear/scroll
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
`ifdef CONSOLE_SCROLL_EN
      r_rsel  <= 1'b0;
      r_raddr <= '0;
      r_copy  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
`ifdef CONSOLE_SCROLL_EN
      r_rsel  <= w_rsel_nxt;
      r_raddr <= w_raddr_nxt;
      r_copy  <= w_copy_nxt;
`endif
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ram_we     = r_we;
  assign ram_waddr  = r_waddr;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

`ifdef CONSOLE_SCROLL_EN
  // Copy writes forward the registered RAM read data in the same cycle it
  // arrives, keeping the scroll at one cell per cycle.
  assign ram_wdata = r_copy ? ram_rdata : r_wdata;
  assign ram_rsel  = r_rsel;
  assign ram_raddr = r_raddr;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^ram_rdata;
  assign ram_wdata      = r_wdata;
  assign ram_rsel       = 1'b0;
  assign ram_raddr      = '0;
`endif

endmodule

// File: tb/tb_screen_console_ctrl.sv
// Bench for screen_console_ctrl: randomized and directed character stream,
// a screen-level reference model, and a write scoreboard with cycle stamps.
module tb_screen_console_ctrl;

  localparam int COLS   = 128;
  localparam int ROWS   = 80;
  localparam int ADDR_W = 15;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_char = 8'h00;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic              ram_rsel;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdata;
  logic [6:0]        cursor_row;
  logic [6:0]        cursor_col;
  logic              busy;

  screen_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_rsel   (ram_rsel),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Screen RAM with registered read, zero when not selected
  logic [7:0] mem [CELLS];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= ram_rsel ? mem[ram_raddr] : 8'h00;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: screen contents, cursor, first cycle the DUT is free
  int scr [CELLS];
  int mrow = 0;
  int mcol = 0;
  int ready_at = 0;
  int last_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic push(input int c, input int a, input int d);
    wr_t e;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic model_nl(input int n);
    if (mrow == ROWS - 1) begin
`ifdef CONSOLE_SCROLL_EN
      for (int k = 0; k < (ROWS - 1) * COLS; k++) begin
        push(n + 2 + k, k, scr[k + COLS]);
        scr[k] = scr[k + COLS];
      end
      for (int j = 0; j < COLS; j++) begin
        push(n + 2 + (ROWS - 1) * COLS + j, (ROWS - 1) * COLS + j, 0);
        scr[(ROWS - 1) * COLS + j] = 0;
      end
      ready_at = n + 2 + CELLS;
`else
      mrow = 0;
`endif
    end else begin
      mrow++;
    end
  endtask

  task automatic model_step(input logic [7:0] ch, input int n);
    int a;
    a = mrow * COLS + mcol;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      push(n + 1, a, int'(ch));
      scr[a] = int'(ch);
      if (mcol == COLS - 1) begin
        mcol = 0;
        model_nl(n);
      end else begin
        mcol++;
      end
    end else if (ch == 8'h0A) begin
      mcol = 0;
      model_nl(n);
    end else if (ch == 8'h0D) begin
      mcol = 0;
    end else if (ch == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push(n + 1, a - 1, 0);
        scr[a - 1] = 0;
      end
    end else if (ch == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) begin
        push(n + 1 + i, i, 0);
        scr[i] = 0;
      end
      mrow = 0;
      mcol = 0;
      ready_at = n + 1 + CELLS;
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after accept.
  task automatic send(input logic [7:0] ch);
    int guard;
    int start;
    int exp_first;
    guard = 0;
    start = cyc;
    while (!in_ready && guard < 12000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("ready_timeout", int'(in_ready), 1);
      finish_run();
    end
    exp_first = (ready_at > start) ? ready_at : start;
    chk("ready_cycle", cyc, exp_first);
    in_valid = 1'b1;
    in_char  = ch;
    last_acc = cyc;
    model_step(ch, cyc);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("cursor_row", int'(cursor_row), mrow);
    chk("cursor_col", int'(cursor_col), mcol);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 80) return 8'h0A;
    if (r < 85) return 8'h0D;
    if (r < 93) return 8'h08;
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return 8'h1B;
      2: return 8'h7F;
      3: return 8'h09;
      default: return 8'($urandom_range(128, 255));
    endcase
  endfunction

  // Scoreboard monitor: every RAM write must match the next expected one
  always @(negedge clk) begin
    if (!reset && ram_we) begin : mon
      wr_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(ram_waddr), -1);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (cyc != e.cyc || int'(ram_waddr) != e.addr || int'(ram_wdata) != e.data) begin
          n_fail++;
          $display("FAIL ram_write: got cycle %0d addr %0d data 0x%02h, expected cycle %0d addr %0d data 0x%02h",
                   cyc, ram_waddr, ram_wdata, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    finish_run();
  end

  initial begin : stim
    int guard;
    int rst_cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_waddr", int'(ram_waddr), 0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);
    chk("rst_ram_rsel", int'(ram_rsel), 0);
    chk("rst_ram_raddr", int'(ram_raddr), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    chk("rst_cursor_col", int'(cursor_col), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // First character straight after reset
    send(8'h41);
    chk("in_ready_after_char", int'(in_ready), 1);

    // Clear screen (also gives the RAM known contents)
    send(8'h0C);
    chk("busy_in_clear", int'(busy), 1);
    chk("in_ready_in_clear", int'(in_ready), 0);

    // A full line back-to-back, ending at (1,0)
    for (int i = 0; i < COLS; i++) send(8'h42);

    // Backspace at column 0 and at column 4 of row 3
    send(8'h0A);
    send(8'h0A);
    send(8'h08);
    send(8'h41);
    send(8'h42);
    send(8'h43);
    send(8'h44);
    send(8'h08);

    // Randomized stream with idle gaps
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(rand_char());
    end

    // Newline on the last row at column 5
    guard = 0;
    while (mrow != ROWS - 1 && guard < 200) begin
      send(8'h0A);
      guard++;
    end
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)));
    send(8'h0A);

    // Printable into the very last cell
    guard = 0;
    while (mrow != ROWS - 1 && guard < 200) begin
      send(8'h0A);
      guard++;
    end
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32, 126)));

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(rand_char());
    end

    // Reset in the middle of a clear, with a character held on the input
    send(8'h0C);
    in_valid = 1'b1;
    in_char  = 8'h55;
    while (cyc < last_acc + 500) @(negedge clk);
    reset   = 1'b1;
    rst_cyc = cyc;
    @(posedge clk);
    #1 reset = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc >= rst_cyc) void'(exp_q.pop_back());
    mrow = 0;
    mcol = 0;
    ready_at = 0;
    @(negedge clk);
    chk("abort_ram_we", int'(ram_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cursor_row", int'(cursor_row), 0);
    chk("abort_cursor_col", int'(cursor_col), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    model_step(8'h55, cyc);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("after_abort_cursor_col", int'(cursor_col), 1);

    // Drain outstanding expected writes
    guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    finish_run();
  end

endmodule
